// File: rtl/hour_counter_set.sv
// hour_counter_set: 0..23 hour counter with set mode, checked load and derived display outputs
module hour_counter_set #(
    parameter int MAX_HR = 23,
    parameter int HR_W   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            min_roll,
    input  logic            set_req,
    input  logic            inc,
    input  logic            dec,
    input  logic            load,
    input  logic [0:HR_W-1] load_val,
    output logic [0:HR_W-1] hr,
    output logic [1:0]      hr_tens,
    output logic [3:0]      hr_units,
    output logic [3:0]      hr12,
    output logic            pm,
    output logic            set_mode,
    output logic            day_tick,
    output logic            load_err
);
    typedef enum logic {RUN, SET} state_t;

    localparam logic [HR_W-1:0] TOP = HR_W'(MAX_HR);

    state_t          state_q, state_d;
    logic [HR_W-1:0] hr_q, hr_d;
    logic [1:0]      tens_q, tens_d;
    logic [3:0]      units_q, units_d, hr12_q, hr12_d;
    logic            pm_q, tick_q, tick_d, err_q, err_d;
    logic            set_p_q, inc_p_q, dec_p_q;
    logic            set_e, inc_e, dec_e;

    assign set_e = set_req & ~set_p_q;
    assign inc_e = inc & ~inc_p_q;
    assign dec_e = dec & ~dec_p_q;

    // next hour/state: load beats set_req, which beats inc/dec; min_roll still lands on a RUN->SET edge
    always_comb begin
        hr_d    = hr_q;
        state_d = state_q;
        tick_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            if (load_val <= TOP) hr_d = load_val;
            else                 err_d = 1'b1;
        end else if (state_q == RUN) begin
            if (min_roll) begin
                hr_d   = (hr_q == TOP) ? '0 : hr_q + 1'b1;
                tick_d = (hr_q == TOP);
            end
            if (set_e) state_d = SET;
        end else if (set_e) begin
            state_d = RUN;
        end else if (inc_e && !dec_e) begin
            hr_d = (hr_q == TOP) ? '0 : hr_q + 1'b1;
        end else if (dec_e && !inc_e) begin
            hr_d = (hr_q == '0) ? TOP : hr_q - 1'b1;
        end
    end

    // display forms derived from the next hour so they move on the same edge as hr
    always_comb begin
        tens_d  = (hr_d >= HR_W'(20)) ? 2'd2 : (hr_d >= HR_W'(10)) ? 2'd1 : 2'd0;
        units_d = 4'((hr_d >= HR_W'(20)) ? hr_d - HR_W'(20) : (hr_d >= HR_W'(10)) ? hr_d - HR_W'(10) : hr_d);
        hr12_d  = 4'((hr_d == '0) ? HR_W'(12) : (hr_d > HR_W'(12)) ? hr_d - HR_W'(12) : hr_d);
    end

    // all state, including button history, with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            hr_q    <= '0;
            tens_q  <= '0;
            units_q <= '0;
            hr12_q  <= 4'd12;
            pm_q    <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
            set_p_q <= 1'b0;
            inc_p_q <= 1'b0;
            dec_p_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hr_q    <= hr_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            hr12_q  <= hr12_d;
            pm_q    <= (hr_d >= HR_W'(12));
            tick_q  <= tick_d;
            err_q   <= err_d;
            set_p_q <= set_req;
            inc_p_q <= inc;
            dec_p_q <= dec;
        end
    end

    assign hr       = hr_q;
    assign hr_tens  = tens_q;
    assign hr_units = units_q;
    assign hr12     = hr12_q;
    assign pm       = pm_q;
    assign set_mode = (state_q == SET);
    assign day_tick = tick_q;
    assign load_err = err_q;
endmodule

// File: tb/tb_hour_counter_set.sv
// tb_hour_counter_set: vector table, directed corner sequences and random run against an hour-arithmetic model
module tb_hour_counter_set;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n, min_roll, set_req, inc, dec, load;
    logic [0:5] load_val, hr;
    logic [1:0] hr_tens;
    logic [3:0] hr_units, hr12;
    logic       pm, set_mode, day_tick, load_err;

    int errs = 0;
    int checks = 0;

    int m_hr;
    bit m_set, m_ps, m_pi, m_pd, m_tick, m_err;

    typedef struct {
        logic       r, m, s, i, d, l;
        logic [5:0] v;
        logic [5:0] eh;
        logic       es, et, ee;
    } vec_t;
    vec_t tbl[$];

    hour_counter_set dut (
        .clk(clk), .rst_n(rst_n), .min_roll(min_roll), .set_req(set_req),
        .inc(inc), .dec(dec), .load(load), .load_val(load_val),
        .hr(hr), .hr_tens(hr_tens), .hr_units(hr_units), .hr12(hr12),
        .pm(pm), .set_mode(set_mode), .day_tick(day_tick), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] exp_of(int h, bit s, bit t, bit e);
        int h12 = (h % 12 == 0) ? 12 : h % 12;
        return {6'(h), 2'(h / 10), 4'(h % 10), 4'(h12), h >= 12, s, t, e};
    endfunction

    function automatic logic [19:0] act();
        return {hr, hr_tens, hr_units, hr12, pm, set_mode, day_tick, load_err};
    endfunction

    task automatic chk(input string name, input logic [19:0] a, input logic [19:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h (hr,tens,units,hr12,pm,set,tick,err)", name, a, e);
        end
    endtask

    // reference: a day is 24 hours counted modulo 24; buttons act on press, not hold
    task automatic model();
        bit se, ie, de;
        if (!rst_n) begin
            m_hr = 0; m_set = 0; m_tick = 0; m_err = 0;
            m_ps = 0; m_pi = 0; m_pd = 0;
            return;
        end
        se = set_req && !m_ps;
        ie = inc && !m_pi;
        de = dec && !m_pd;
        m_tick = 0;
        m_err = 0;
        if (load) begin
            if (load_val <= 6'd23) m_hr = int'(load_val);
            else m_err = 1;
        end else if (!m_set) begin
            if (min_roll) begin
                m_tick = (m_hr == 23);
                m_hr = (m_hr + 1) % 24;
            end
            if (se) m_set = 1;
        end else if (se) begin
            m_set = 0;
        end else if (ie && !de) begin
            m_hr = (m_hr + 1) % 24;
        end else if (de && !ie) begin
            m_hr = (m_hr + 23) % 24;
        end
        m_ps = set_req; m_pi = inc; m_pd = dec;
    endtask

    task automatic cyc(input logic r, m, s, i, d, l, input logic [5:0] v);
        rst_n = r; min_roll = m; set_req = s; inc = i; dec = d; load = l; load_val = v;
        @(posedge clk);
        model();
        #1;
        chk("model", act(), exp_of(m_hr, m_set, m_tick, m_err));
    endtask

    initial begin
        rst_n = 0; min_roll = 0; set_req = 0; inc = 0; dec = 0; load = 0; load_val = 0;
        //                r  m  s  i  d  l  val     exp_hr  set tick err
        tbl.push_back('{L, L, L, L, L, L, 6'd0,  6'd0,  L, L, L});
        tbl.push_back('{H, L, L, L, L, H, 6'd22, 6'd22, L, L, L});
        tbl.push_back('{H, H, L, L, L, L, 6'd0,  6'd23, L, L, L});
        tbl.push_back('{H, H, L, L, L, L, 6'd0,  6'd0,  L, H, L});
        tbl.push_back('{H, L, L, L, L, L, 6'd0,  6'd0,  L, L, L});
        tbl.push_back('{H, L, L, L, L, H, 6'd30, 6'd0,  L, L, H});
        tbl.push_back('{H, L, L, L, L, H, 6'd12, 6'd12, L, L, L});
        tbl.push_back('{H, L, L, L, L, L, 6'd0,  6'd12, L, L, L});
        tbl.push_back('{H, L, L, L, L, H, 6'd23, 6'd23, L, L, L});
        tbl.push_back('{H, L, L, L, L, H, 6'd24, 6'd23, L, L, H});
        tbl.push_back('{H, L, L, L, L, H, 6'd63, 6'd23, L, L, H});
        tbl.push_back('{H, L, L, L, L, H, 6'd0,  6'd0,  L, L, L});
        tbl.push_back('{H, L, L, H, L, L, 6'd0,  6'd0,  L, L, L});
        tbl.push_back('{H, L, L, L, H, L, 6'd0,  6'd0,  L, L, L});
        tbl.push_back('{H, L, H, L, L, L, 6'd0,  6'd0,  H, L, L});
        tbl.push_back('{H, L, H, H, L, L, 6'd0,  6'd1,  H, L, L});
        tbl.push_back('{H, L, L, L, H, L, 6'd0,  6'd0,  H, L, L});
        tbl.push_back('{H, L, L, L, L, L, 6'd0,  6'd0,  H, L, L});
        tbl.push_back('{H, L, L, L, H, L, 6'd0,  6'd23, H, L, L});
        tbl.push_back('{H, L, L, H, L, L, 6'd0,  6'd0,  H, L, L});
        tbl.push_back('{H, H, L, L, L, L, 6'd0,  6'd0,  H, L, L});
        tbl.push_back('{H, L, L, L, L, H, 6'd5,  6'd5,  H, L, L});
        tbl.push_back('{H, L, H, H, L, L, 6'd0,  6'd5,  L, L, L});
        tbl.push_back('{H, H, L, L, L, L, 6'd0,  6'd6,  L, L, L});
        foreach (tbl[k]) begin
            cyc(tbl[k].r, tbl[k].m, tbl[k].s, tbl[k].i, tbl[k].d, tbl[k].l, tbl[k].v);
            chk($sformatf("vec%0d", k), act(), exp_of(int'(tbl[k].eh), tbl[k].es, tbl[k].et, tbl[k].ee));
        end

        // full day of rollovers from reset
        cyc(L, L, L, L, L, L, 6'd0);
        chk("reset", act(), exp_of(0, 0, 0, 0));
        repeat (23) cyc(H, H, L, L, L, L, 6'd0);
        chk("hr23", act(), exp_of(23, 0, 0, 0));
        cyc(H, H, L, L, L, L, 6'd0);
        chk("day_wrap", act(), exp_of(0, 0, 1, 0));
        cyc(H, L, L, L, L, L, 6'd0);
        chk("tick_once", act(), exp_of(0, 0, 0, 0));

        // set entry coincident with min_roll, then frozen time and wraps in SET
        cyc(H, L, L, L, L, H, 6'd22);
        cyc(H, H, H, L, L, L, 6'd0);
        chk("set_with_roll", act(), exp_of(23, 1, 0, 0));
        cyc(H, H, L, L, L, L, 6'd0);
        chk("set_frozen", act(), exp_of(23, 1, 0, 0));
        cyc(H, L, L, H, L, L, 6'd0);
        chk("set_inc_wrap", act(), exp_of(0, 1, 0, 0));
        cyc(H, L, L, L, H, L, 6'd0);
        chk("set_dec_wrap", act(), exp_of(23, 1, 0, 0));

        // held inc counts once, simultaneous inc/dec cancel, set_req exit ignores inc
        cyc(H, L, L, L, L, L, 6'd0);
        repeat (10) cyc(H, L, L, H, L, L, 6'd0);
        chk("inc_held", act(), exp_of(0, 1, 0, 0));
        cyc(H, L, L, L, L, L, 6'd0);
        cyc(H, L, L, H, H, L, 6'd0);
        chk("inc_dec_both", act(), exp_of(0, 1, 0, 0));
        cyc(H, L, L, L, L, L, 6'd0);
        cyc(H, L, H, H, L, L, 6'd0);
        chk("set_exit", act(), exp_of(0, 0, 0, 0));

        // reset in the middle of SET
        cyc(H, L, L, L, L, L, 6'd0);
        cyc(H, L, H, L, L, L, 6'd0);
        cyc(H, L, L, L, L, H, 6'd5);
        chk("set_hr5", act(), exp_of(5, 1, 0, 0));
        cyc(L, H, H, H, L, H, 6'd7);
        chk("reset_in_set", act(), exp_of(0, 0, 0, 0));
        cyc(H, H, L, L, L, L, 6'd0);
        chk("run_after_reset", act(), exp_of(1, 0, 0, 0));

        // random traffic against the model
        for (int n = 0; n < 3000; n++)
            cyc($urandom_range(199) != 0, $urandom_range(2) == 0, $urandom_range(5) == 0,
                $urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(9) == 0,
                6'($urandom_range(63)));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/hour_counter_set.md
Name: hour_counter_set

Overview:
Hour-of-day generator for the digital clock. It advances 0..23 on each minute-rollover strobe and wraps after 23, so the 23-terminal-count comparator and this block sit at opposite ends of the same hour bus. It also supports a user set mode (increment/decrement) and a direct load with range checking. It publishes the binary hour, BCD digits, 12-hour form and a day-rollover strobe to the display and calendar logic.

Parameters:
MAX_HR, 23, terminal hour value; the next advance wraps to 0.
HR_W, 6, hour bus width.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
min_roll  input  1  one-cycle strobe from the minute counter when it wraps 59->0.
set_req  input  1  debounced set-mode button, level; the rising edge is detected internally.
inc  input  1  debounced increment button, level; the rising edge is detected internally.
dec  input  1  debounced decrement button, level; the rising edge is detected internally.
load  input  1  one-cycle strobe: load load_val.
load_val  input  [0:5]  hour value to load; index 0 is the MSB.
hr  output  [0:5]  current hour in binary, 0..23; index 0 is the MSB, the same ordering as the hour-comparator input.
hr_tens  output  2  BCD tens digit, 0..2.
hr_units  output  4  BCD units digit, 0..9.
hr12  output  4  12-hour value, 1..12.
pm  output  1  1 when hr >= 12.
set_mode  output  1  1 while in SET state.
day_tick  output  1  one-cycle strobe on the 23->0 wrap in RUN only.
load_err  output  1  one-cycle strobe when a load is rejected.

Behaviour:
- Reset (rst_n=0 at an edge):
  - hr=0, hr_tens=0, hr_units=0, hr12=12, pm=0.
  - set_mode=0, day_tick=0, load_err=0, state=RUN.
  - Edge-detect history registers are cleared to 0.
  - Reset overrides every other input, including in mid-SET or during a load.
- Edge detection: for each of set_req, inc and dec, the internal edge signal is input AND NOT previous-cycle sample. A button held high produces exactly one event.
- Priority per cycle: reset > load > set_req edge > (inc/dec edges or min_roll).
- Load:
  - If load_val <= MAX_HR: hr=load_val at the next edge; state is unchanged.
  - If load_val > MAX_HR (24..63): hr is unchanged and load_err=1 for one cycle.
  - Any other event in the same cycle is discarded.
- State RUN:
  - min_roll=1 and hr<MAX_HR: hr=hr+1.
  - min_roll=1 and hr==MAX_HR: hr=0 and day_tick=1 on the same edge.
  - inc and dec edges are ignored.
  - set_req edge: go to SET, set_mode=1. A coincident min_roll is still applied on that edge, so no hour is lost.
- State SET:
  - min_roll is ignored, so time is frozen and no missed rollovers are queued.
  - inc edge alone: hr+1, wrapping MAX_HR->0, with no day_tick.
  - dec edge alone: hr-1, wrapping 0->MAX_HR.
  - inc and dec edges in the same cycle: no change.
  - set_req edge: go to RUN, set_mode=0. Coincident inc/dec edges are ignored.
- Derived outputs (hr_tens, hr_units, hr12, pm) are registered and computed from the next hr value. They change on the same edge as hr, with no extra latency.
- hr12 mapping: 0->12, 1..12->same value, 13..23->hr-12.
- day_tick and load_err are high for exactly one cycle and never stretch.
- hr never holds a value above MAX_HR by any path.

Test Plan:
- Reset then 23 min_roll pulses -> hr=23, hr_tens=2, hr_units=3, hr12=11, pm=1; the next min_roll -> hr=0, hr12=12, pm=0, day_tick=1 for one cycle only.
- load with load_val=30 -> hr is unchanged and load_err=1 for one cycle; load with load_val=12 -> hr=12, hr12=12, pm=1, load_err=0.
- hr=22: set_req edge together with min_roll -> hr=23 and set_mode=1; a further min_roll -> hr stays 23; an inc edge -> hr=0 with day_tick=0; a dec edge -> hr=23.
- In SET, hold inc high for 10 cycles -> exactly one increment; assert inc and dec rising together -> no change; a set_req edge with inc -> RUN, hr unchanged.
- In SET at hr=5, drive rst_n=0 for one edge -> hr=0, set_mode=0, state=RUN; a subsequent min_roll -> hr=1.
